// File: rtl/slowmem_cache_ctrl_pkg.sv
// Shared widths, slowmem timing, FSM encodings and processor sentinels for the
// slowmem cache controller.
package slowmem_cache_ctrl_pkg;
  localparam int WORD_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int MEMDELAY = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [3:0]        NOREG  = 4'hF;
  localparam logic [ADDR_W-1:0] NOADDR = '1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/slowmem_cache_ctrl_cache_line_store.sv
// Direct-mapped valid/tag/data array: combinational lookup, one write port,
// flush-all and async clear of the valid bits.
module cache_line_store #(
  parameter int LINES = 8,
  parameter int IW    = 3,
  parameter int TW    = 13,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic [IW-1:0] i_lk_idx,
  input  logic [TW-1:0] i_lk_tag,
  output logic          o_hit,
  output logic [DW-1:0] o_data,
  input  logic          i_we,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [TW-1:0] i_wr_tag,
  input  logic [DW-1:0] i_wr_data
);
  logic [LINES-1:0]         r_valid;
  logic [LINES-1:0][TW-1:0] r_tag;
  logic [LINES-1:0][DW-1:0] r_data;

  assign o_hit  = r_valid[i_lk_idx] && (r_tag[i_lk_idx] == i_lk_tag);
  assign o_data = r_data[i_lk_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_valid <= '0;
    else if (i_flush) r_valid <= '0;
    else if (i_we)    r_valid[i_wr_idx] <= 1'b1;
  end

  // Tag/data need no reset: nothing is read while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end
endmodule

// File: rtl/slowmem_cache_ctrl.sv
// Write-through, direct-mapped, one-word-line cache in front of slowmem.
// Read misses issue a single strobe and are reissued after TIMEOUT wait cycles.
module slowmem_cache_ctrl
  import slowmem_cache_ctrl_pkg::*;
#(
  parameter int LINES   = 8,
  parameter int AW      = ADDR_W,
  parameter int DW      = WORD_W,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          flush,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [15:0]   hits,
  output logic [15:0]   misses,
  output logic          m_strobe,
  output logic          m_rnotw,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_mfc,
  input  logic [DW-1:0] m_rdata
);
  localparam int IW = $clog2(LINES);
  localparam int TW = AW - IW;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_wcnt;

  logic          w_acc, w_hit, w_fill, w_st_we, w_flush;
  logic [DW-1:0] w_lk_data;
  logic [IW-1:0] w_wr_idx;
  logic [TW-1:0] w_wr_tag;
  logic [DW-1:0] w_wr_data;

  assign ready   = (r_state == S_IDLE) && !flush;
  assign w_acc   = ready && req;
  assign w_flush = (r_state == S_IDLE) && flush;
  // m_mfc only counts while a read is outstanding; elsewhere it is stale.
  assign w_fill  = (r_state == S_WAIT) && m_mfc;
  assign w_st_we = w_fill || (w_acc && we && w_hit);

  assign w_wr_idx  = w_fill ? r_addr[IW-1:0]  : addr[IW-1:0];
  assign w_wr_tag  = w_fill ? r_addr[AW-1:IW] : addr[AW-1:IW];
  assign w_wr_data = w_fill ? m_rdata         : wdata;

  cache_line_store #(.LINES(LINES), .IW(IW), .TW(TW), .DW(DW)) u_store (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (w_flush),
    .i_lk_idx  (addr[IW-1:0]),
    .i_lk_tag  (addr[AW-1:IW]),
    .o_hit     (w_hit),
    .o_data    (w_lk_data),
    .i_we      (w_st_we),
    .i_wr_idx  (w_wr_idx),
    .i_wr_tag  (w_wr_tag),
    .i_wr_data (w_wr_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wcnt   <= '0;
      done     <= 1'b0;
      rdata    <= '0;
      hits     <= '0;
      misses   <= '0;
      m_strobe <= 1'b0;
      m_rnotw  <= 1'b1;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else begin
      done     <= 1'b0;
      m_strobe <= 1'b0;
      case (r_state)
        S_IDLE: if (w_acc) begin
          if (we) begin
            m_strobe <= 1'b1;
            m_rnotw  <= 1'b0;
            m_addr   <= addr;
            m_wdata  <= wdata;
            done     <= 1'b1;
          end else if (w_hit) begin
            done  <= 1'b1;
            rdata <= w_lk_data;
            hits  <= sat_inc(hits);
          end else begin
            r_state  <= S_ISSUE;
            r_addr   <= addr;
            m_strobe <= 1'b1;
            m_rnotw  <= 1'b1;
            m_addr   <= addr;
            misses   <= sat_inc(misses);
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_wcnt  <= '0;
        end
        S_WAIT: begin
          if (m_mfc) begin
            done    <= 1'b1;
            rdata   <= m_rdata;
            r_state <= S_IDLE;
          end else if (r_wcnt == CW'(TIMEOUT)) begin
            r_state  <= S_ISSUE;
            r_wcnt   <= '0;
            m_strobe <= 1'b1;
            m_rnotw  <= 1'b1;
            m_addr   <= r_addr;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
